i2c_txn_arbiter: RTL and testbench
==================================

Name: i2c_txn_arbiter

Overview:
- Shares one I2C byte engine between NREQ requesters (e.g. audio DAC streamer, board-config client).
- Each requester posts a whole write transaction: 7-bit address plus 1..4 data bytes.
- The block arbitrates round-robin and drives the engine's halt/enable/din/ready handshake byte by byte.
- It then issues STOP and enforces bus-free time before the next START.

Parameters:
- NREQ, 2, number of requesters (2..4).
- GAP_CYCLES, 256, clk cycles halt is held high after a transaction before the next START may begin (covers STOP plus bus-free time at 400 kHz, 48 MHz clk).

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low.
- req_valid  in  NREQ  per-requester transaction request; held until req_ack.
- req_addr  in  7*NREQ  slave address, requester i at [7i+6:7i].
- req_len  in  2*NREQ  byte count minus 1 (0 = 1 byte, 3 = 4 bytes).
- req_data  in  32*NREQ  payload; byte 0 = [32i+31:32i+24], sent first.
- req_ack  out  NREQ  1-cycle pulse: request captured; requester may change inputs.
- req_done  out  NREQ  1-cycle pulse: transaction finished (STOP issued).
- req_nack  out  1  valid with req_done: 1 = a byte was not acknowledged.
- busy  out  1  high from capture until end of GAP.
- eng_halt  out  1  to engine halt; high = release bus / STOP.
- eng_enable  out  1  to engine enable.
- eng_din  out  8  to engine din.
- eng_ready  in  1  engine 1-cycle byte-complete pulse.
- eng_ack  in  1  engine ac bit sampled on the byte (0 = ACK, 1 = NACK).

Behaviour:
- Reset values (reset_n low at a clk edge):
  - state=IDLE, eng_halt=1, eng_enable=0, eng_din=0.
  - req_ack=0, req_done=0, req_nack=0, busy=0.
  - rr pointer=0, gap counter=0.
- Reset asserted mid-transaction: same values next cycle; eng_halt=1 forces the engine to STOP. No req_done is emitted.
- States: IDLE, ADDR, DATA, STOP, GAP.
- IDLE:
  - If any req_valid, grant the first requester at or after the rr pointer (wrapping at NREQ).
  - Capture its addr/len/data into shadow registers and pulse req_ack[g] in the same edge.
  - Set busy=1, eng_halt=0, eng_din={addr,1'b0}, eng_enable=1, byte index=0. Go to ADDR.
  - rr pointer := g+1 mod NREQ.
- ADDR: hold eng_din/eng_enable until eng_ready.
  - On eng_ready with eng_ack=0: eng_din := byte 0, go to DATA.
  - On eng_ready with eng_ack=1: nack flag := 1, eng_enable := 0, go to STOP.
- DATA: hold until eng_ready.
  - If eng_ack=1: set nack flag, go to STOP.
  - Else if byte index==len: go to STOP.
  - Else index+1, eng_din := next byte.
  - eng_din changes only on the cycle after an eng_ready pulse.
- STOP (one cycle):
  - eng_enable=0, eng_halt=1.
  - Pulse req_done[g] with req_nack=nack flag; clear the flag.
  - Load gap counter=GAP_CYCLES-1, go to GAP.
- GAP:
  - Decrement each cycle; eng_halt stays 1; no grant.
  - At 0: busy=0, go to IDLE. The next grant can occur the following cycle.
- eng_ready outside ADDR/DATA is ignored.
- A req_valid that drops before grant is simply not served; a dropped request after req_ack has no effect (data is shadowed).
- Multiple simultaneous req_valid: exactly one req_ack per transaction; the others wait.
- Starvation bound: a continuously valid requester waits at most NREQ-1 transactions.
- Byte count is len+1; the address byte is not counted. Maximum 5 engine bytes per transaction.

Test Plan:
- Single requester 0, addr=7'h60, len=1, data=32'h0ABC_0000 with an engine model that ACKs every byte:
  - eng_din sequence C0, 0A, BC.
  - Exactly 3 eng_enable phases, then req_done[0] with req_nack=0.
  - busy falls GAP_CYCLES cycles after STOP.
- Both requesters valid from reset, each len=0:
  - Grant order 0,1,0,1 over 4 transactions; req_ack pulses one per transaction.
  - No START (eng_halt falling) occurs during GAP.
- Address NACK (eng_ack=1 on the first byte):
  - No data bytes are sent.
  - eng_halt rises the next cycle; req_done with req_nack=1.
  - The next transaction's req_nack=0.
- NACK on data byte 2 of len=3:
  - Bytes 3 and 4 are never presented.
  - req_done/req_nack=1 follow one cycle after that eng_ready.
- reset_n low during DATA:
  - Next cycle eng_halt=1, eng_enable=0, busy=0, no req_done.
  - After release a pending request is granted from requester 0.
- req_data changed by the requester the cycle after req_ack:
  - The transmitted bytes equal the captured values.

Source files
------------

// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter sharing one I2C byte engine between NREQ write requesters.
// Shadows each granted transaction, then sequences address, data bytes, STOP and bus-free gap.
module i2c_txn_arbiter #(
  parameter int unsigned NREQ       = 2,
  parameter int unsigned GAP_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [7*NREQ-1:0]    req_addr,
  input  logic [2*NREQ-1:0]    req_len,
  input  logic [32*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      req_done,
  output logic                 req_nack,
  output logic                 busy,
  output logic                 eng_halt,
  output logic                 eng_enable,
  output logic [7:0]           eng_din,
  input  logic                 eng_ready,
  input  logic                 eng_ack
);

  localparam int unsigned PW = (NREQ > 2) ? 2 : 1;
  localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_STOP,
    S_GAP
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     grant_q, grant_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [1:0]        len_q, len_d;
  logic [31:0]       data_q, data_d;
  logic [1:0]        idx_q, idx_d;
  logic              nack_q, nack_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              busy_q, busy_d;
  logic              halt_q, halt_d;
  logic              enable_q, enable_d;
  logic [7:0]        din_q, din_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic [NREQ-1:0]   done_q, done_d;
  logic              rnack_q, rnack_d;

  logic              found;
  logic [PW-1:0]     sel;
  logic [PW-1:0]     cand;
  logic [6:0]        cap_addr;
  logic [1:0]        cap_len;
  logic [31:0]       cap_data;
  logic              go_stop;
  logic              nack_set;

  // First valid requester at or after the round-robin pointer, plus its fields.
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    cand     = '0;
    cap_addr = '0;
    cap_len  = '0;
    cap_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PW'((32'(rr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (sel == PW'(k)) begin
        cap_addr = req_addr[7*k +: 7];
        cap_len  = req_len[2*k +: 2];
        cap_data = req_data[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    len_d    = len_q;
    data_d   = data_q;
    idx_d    = idx_q;
    nack_d   = nack_q;
    gap_d    = gap_q;
    busy_d   = busy_q;
    halt_d   = halt_q;
    enable_d = enable_q;
    din_d    = din_q;
    ack_d    = '0;
    done_d   = '0;
    rnack_d  = 1'b0;
    go_stop  = 1'b0;
    nack_set = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d    = sel;
          rr_d       = PW'((32'(sel) + 1) % NREQ);
          len_d      = cap_len;
          data_d     = cap_data;
          idx_d      = '0;
          ack_d[sel] = 1'b1;
          busy_d     = 1'b1;
          halt_d     = 1'b0;
          enable_d   = 1'b1;
          din_d      = {cap_addr, 1'b0};
          state_d    = S_ADDR;
        end
      end
      S_ADDR: begin
        if (eng_ready) begin
          if (eng_ack) begin
            go_stop  = 1'b1;
            nack_set = 1'b1;
          end else begin
            din_d   = data_q[31:24];
            data_d  = {data_q[23:0], 8'h00};
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (eng_ready) begin
          if (eng_ack) begin
            go_stop  = 1'b1;
            nack_set = 1'b1;
          end else if (idx_q == len_q) begin
            go_stop = 1'b1;
          end else begin
            idx_d  = idx_q + 1'b1;
            din_d  = data_q[31:24];
            data_d = {data_q[23:0], 8'h00};
          end
        end
      end
      S_STOP: begin
        nack_d  = 1'b0;
        gap_d   = GW'(GAP_CYCLES - 1);
        state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_q == '0) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // STOP outputs are registered on entry so halt/done are visible during the STOP cycle.
    if (go_stop) begin
      state_d         = S_STOP;
      enable_d        = 1'b0;
      halt_d          = 1'b1;
      nack_d          = nack_q | nack_set;
      rnack_d         = nack_q | nack_set;
      done_d[grant_q] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      len_q    <= '0;
      data_q   <= '0;
      idx_q    <= '0;
      nack_q   <= 1'b0;
      gap_q    <= '0;
      busy_q   <= 1'b0;
      halt_q   <= 1'b1;
      enable_q <= 1'b0;
      din_q    <= '0;
      ack_q    <= '0;
      done_q   <= '0;
      rnack_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      len_q    <= len_d;
      data_q   <= data_d;
      idx_q    <= idx_d;
      nack_q   <= nack_d;
      gap_q    <= gap_d;
      busy_q   <= busy_d;
      halt_q   <= halt_d;
      enable_q <= enable_d;
      din_q    <= din_d;
      ack_q    <= ack_d;
      done_q   <= done_d;
      rnack_q  <= rnack_d;
    end
  end

  assign req_ack    = ack_q;
  assign req_done   = done_q;
  assign req_nack   = rnack_q;
  assign busy       = busy_q;
  assign eng_halt   = halt_q;
  assign eng_enable = enable_q;
  assign eng_din    = din_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Bench for i2c_txn_arbiter: engine model, event logger and per-scenario checks
// against a transaction-level reference of grants, byte streams and timing.
module tb_i2c_txn_arbiter;
  localparam int unsigned NREQ = 2;
  localparam int unsigned GAP  = 32;

  logic              clk;
  logic              reset_n;
  logic [NREQ-1:0]   req_valid;
  logic [7*NREQ-1:0] req_addr;
  logic [2*NREQ-1:0] req_len;
  logic [32*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic [NREQ-1:0]   req_done;
  logic              req_nack;
  logic              busy;
  logic              eng_halt;
  logic              eng_enable;
  logic [7:0]        eng_din;
  logic              eng_ready;
  logic              eng_ack;

  i2c_txn_arbiter #(.NREQ(NREQ), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_len(req_len), .req_data(req_data), .req_ack(req_ack), .req_done(req_done),
    .req_nack(req_nack), .busy(busy), .eng_halt(eng_halt), .eng_enable(eng_enable),
    .eng_din(eng_din), .eng_ready(eng_ready), .eng_ack(eng_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  int          nack_at = 99;
  int unsigned eng_lat = 1;
  bit          auto_drop = 1'b0;
  int unsigned model_rr = 0;

  logic [7:0]      byte_q[$];
  logic [7:0]      exp_q[$];
  int unsigned     rdy_cyc_q[$];
  logic [NREQ-1:0] ack_q[$];
  logic [NREQ-1:0] done_q[$];
  logic            nack_q[$];
  int unsigned     done_cyc_q[$];
  int unsigned     start_q[$];
  int unsigned     hrise_q[$];
  int unsigned     bfall_q[$];

  // Engine: after eng_lat idle cycles of enable, completes the byte; NACKs byte nack_at.
  initial begin
    int unsigned lat;
    int          ebyte;
    lat = 0; ebyte = 0;
    eng_ready = 1'b0; eng_ack = 1'b0;
    forever begin
      @(negedge clk);
      eng_ready = 1'b0; eng_ack = 1'b0;
      if (eng_halt || !reset_n) begin
        ebyte = 0; lat = 0;
      end else if (eng_enable) begin
        if (lat >= eng_lat) begin
          eng_ready = 1'b1;
          eng_ack   = (ebyte == nack_at);
          byte_q.push_back(eng_din);
          rdy_cyc_q.push_back(cyc + 1);
          ebyte++; lat = 0;
        end else begin
          lat++;
        end
      end
    end
  end

  initial begin
    logic prev_halt, prev_busy;
    prev_halt = 1'b1; prev_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (req_ack != '0) ack_q.push_back(req_ack);
      if (req_done != '0) begin
        done_q.push_back(req_done);
        nack_q.push_back(req_nack);
        done_cyc_q.push_back(cyc);
      end
      if (prev_halt && !eng_halt) start_q.push_back(cyc);
      if (!prev_halt && eng_halt) hrise_q.push_back(cyc);
      if (prev_busy && !busy) bfall_q.push_back(cyc);
      prev_halt = eng_halt; prev_busy = busy;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (auto_drop) req_valid = req_valid & ~req_ack;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic clear_logs();
    byte_q.delete(); exp_q.delete(); rdy_cyc_q.delete(); ack_q.delete(); done_q.delete();
    nack_q.delete(); done_cyc_q.delete(); start_q.delete(); hrise_q.delete(); bfall_q.delete();
  endtask

  task automatic set_req(input int unsigned i, input logic [6:0] a, input logic [1:0] l,
                         input logic [31:0] d);
    req_addr[7*i +: 7]  = a;
    req_len[2*i +: 2]   = l;
    req_data[32*i +: 32] = d;
  endtask

  // Expected engine byte stream: address+W, then payload bytes until len or the NACKed byte.
  function automatic void expect_txn(input logic [6:0] a, input logic [1:0] l,
                                     input logic [31:0] d, input int na);
    exp_q.push_back({a, 1'b0});
    if (na == 0) return;
    for (int k = 0; k <= int'(l); k++) begin
      exp_q.push_back(d[31-8*k -: 8]);
      if (na == k + 1) return;
    end
  endfunction

  function automatic int unsigned rr_pick(input logic [NREQ-1:0] mask);
    for (int unsigned k = 0; k < NREQ; k++)
      if (mask[(model_rr + k) % NREQ]) return (model_rr + k) % NREQ;
    return 0;
  endfunction

  task automatic wait_dones(input int unsigned n, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned t = 0; t < budget && !ok; t++) begin
      @(negedge clk);
      if (done_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_acks(input int unsigned n, input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned t = 0; t < budget && !ok; t++) begin
      @(negedge clk);
      if (ack_q.size() >= n) ok = 1'b1;
    end
  endtask

  task automatic wait_idle(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned t = 0; t < budget && !ok; t++) begin
      @(negedge clk);
      if (!busy) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    req_valid = '0; req_addr = '0; req_len = '0; req_data = '0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (eng_halt !== 1'b1) begin fails++; $display("FAIL reset_halt got=%b exp=1", eng_halt); end
    tests++; if (eng_enable !== 1'b0) begin fails++; $display("FAIL reset_enable got=%b exp=0", eng_enable); end
    tests++; if (eng_din !== 8'h00) begin fails++; $display("FAIL reset_din got=%h exp=00", eng_din); end
    tests++; if (req_ack !== '0) begin fails++; $display("FAIL reset_ack got=%b exp=0", req_ack); end
    tests++; if (req_done !== '0) begin fails++; $display("FAIL reset_done got=%b exp=0", req_done); end
    tests++; if (req_nack !== 1'b0) begin fails++; $display("FAIL reset_nack got=%b exp=0", req_nack); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    req_valid = 2'b11;
    @(negedge clk);
    tests++; if (req_ack !== '0) begin fails++; $display("FAIL reset_no_grant got=%b exp=0", req_ack); end
    req_valid = '0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    model_rr = 0;
  endtask

  task automatic test_round_robin();
    logic [6:0]  ra[NREQ];
    logic [31:0] rd[NREQ];
    int unsigned g[4];
    bit ok;
    for (int unsigned i = 0; i < NREQ; i++) begin
      ra[i] = 7'($urandom); rd[i] = $urandom;
      set_req(i, ra[i], 2'd0, rd[i]);
    end
    auto_drop = 1'b0; eng_lat = 1; nack_at = 99;
    reset_n = 1'b0; req_valid = 2'b11;
    repeat (2) @(negedge clk);
    clear_logs();
    reset_n = 1'b1; model_rr = 0;
    wait_dones(4, 4 * (GAP + 40), ok);
    req_valid = '0;
    tests++; if (!ok) begin fails++; $display("FAIL rr_timeout got=%0d dones exp=4", done_q.size()); end
    for (int t = 0; t < 4; t++) begin
      g[t] = rr_pick(2'b11);
      model_rr = (g[t] + 1) % NREQ;
      expect_txn(ra[g[t]], 2'd0, rd[g[t]], 99);
    end
    tests++; if (ack_q.size() != 4) begin fails++; $display("FAIL rr_ack_count got=%0d exp=4", ack_q.size()); end
    for (int t = 0; t < 4 && t < ack_q.size() && t < done_q.size(); t++) begin
      tests++;
      if (ack_q[t] !== NREQ'(1 << g[t]) || done_q[t] !== NREQ'(1 << g[t])) begin
        fails++; $display("FAIL rr_grant%0d got ack=%b done=%b exp=%b", t, ack_q[t], done_q[t], NREQ'(1 << g[t]));
      end
    end
    tests++; if (byte_q.size() != exp_q.size()) begin fails++; $display("FAIL rr_byte_count got=%0d exp=%0d", byte_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      tests++; if (byte_q[i] !== exp_q[i]) begin fails++; $display("FAIL rr_byte%0d got=%h exp=%h", i, byte_q[i], exp_q[i]); end
    end
    for (int t = 1; t < 4 && t < start_q.size() && t <= done_cyc_q.size(); t++) begin
      tests++;
      if (start_q[t] - done_cyc_q[t-1] != GAP + 2) begin
        fails++; $display("FAIL rr_gap_start%0d got=%0d exp=%0d", t, start_q[t] - done_cyc_q[t-1], GAP + 2);
      end
    end
    wait_idle(GAP + 20, ok);
  endtask

  task automatic test_single();
    logic [7:0] exp_b[3];
    bit ok, ok2;
    exp_b[0] = 8'hC0; exp_b[1] = 8'h0A; exp_b[2] = 8'hBC;
    set_req(0, 7'h60, 2'd1, 32'h0ABC_0000);
    clear_logs(); auto_drop = 1'b1; eng_lat = 2; nack_at = 99;
    req_valid = 2'b01;
    wait_dones(1, 200, ok);
    wait_idle(GAP + 20, ok2);
    model_rr = 1;
    tests++; if (!(ok && ok2)) begin fails++; $display("FAIL single_timeout got=%b%b exp=11", ok, ok2); end
    tests++; if (byte_q.size() != 3) begin fails++; $display("FAIL single_byte_count got=%0d exp=3", byte_q.size()); end
    for (int i = 0; i < 3 && i < byte_q.size(); i++) begin
      tests++; if (byte_q[i] !== exp_b[i]) begin fails++; $display("FAIL single_byte%0d got=%h exp=%h", i, byte_q[i], exp_b[i]); end
    end
    if (done_q.size() > 0 && ack_q.size() > 0 && bfall_q.size() > 0) begin
      tests++; if (ack_q[0] !== 2'b01) begin fails++; $display("FAIL single_ack got=%b exp=01", ack_q[0]); end
      tests++; if (done_q[0] !== 2'b01) begin fails++; $display("FAIL single_done got=%b exp=01", done_q[0]); end
      tests++; if (nack_q[0] !== 1'b0) begin fails++; $display("FAIL single_nack got=%b exp=0", nack_q[0]); end
      tests++;
      if (bfall_q[0] - done_cyc_q[0] != GAP + 1) begin
        fails++; $display("FAIL single_busy_fall got=%0d exp=%0d", bfall_q[0] - done_cyc_q[0], GAP + 1);
      end
    end else begin
      tests++; fails++; $display("FAIL single_events got=%0d/%0d/%0d exp=1/1/1", ack_q.size(), done_q.size(), bfall_q.size());
    end
  endtask

  task automatic test_addr_nack();
    logic [6:0]  a;
    logic [1:0]  l;
    logic [31:0] d;
    bit ok, ok2;
    a = 7'($urandom); l = 2'($urandom); d = $urandom;
    set_req(1, a, l, d);
    clear_logs(); auto_drop = 1'b1; eng_lat = $urandom_range(0, 3); nack_at = 0;
    req_valid = 2'b10;
    wait_dones(1, 200, ok);
    wait_idle(GAP + 20, ok2);
    model_rr = 0;
    tests++; if (!(ok && ok2)) begin fails++; $display("FAIL anack_timeout got=%b%b exp=11", ok, ok2); end
    tests++; if (byte_q.size() != 1) begin fails++; $display("FAIL anack_byte_count got=%0d exp=1", byte_q.size()); end
    if (byte_q.size() > 0 && done_q.size() > 0 && hrise_q.size() > 0) begin
      tests++; if (byte_q[0] !== {a, 1'b0}) begin fails++; $display("FAIL anack_addr got=%h exp=%h", byte_q[0], {a, 1'b0}); end
      tests++; if (nack_q[0] !== 1'b1) begin fails++; $display("FAIL anack_nack got=%b exp=1", nack_q[0]); end
      tests++; if (done_q[0] !== 2'b10) begin fails++; $display("FAIL anack_done got=%b exp=10", done_q[0]); end
      tests++; if (hrise_q[0] != rdy_cyc_q[0]) begin fails++; $display("FAIL anack_halt_rise got=%0d exp=%0d", hrise_q[0], rdy_cyc_q[0]); end
      tests++; if (done_cyc_q[0] != rdy_cyc_q[0]) begin fails++; $display("FAIL anack_done_cyc got=%0d exp=%0d", done_cyc_q[0], rdy_cyc_q[0]); end
    end else begin
      tests++; fails++; $display("FAIL anack_events got=%0d/%0d/%0d exp=1/1/1", byte_q.size(), done_q.size(), hrise_q.size());
    end
    l = 2'($urandom);
    set_req(0, 7'($urandom), l, $urandom);
    clear_logs(); nack_at = 99;
    req_valid = 2'b01;
    wait_dones(1, 200, ok);
    wait_idle(GAP + 20, ok2);
    model_rr = 1;
    tests++; if (!(ok && ok2)) begin fails++; $display("FAIL anack_next_timeout got=%b%b exp=11", ok, ok2); end
    tests++; if (nack_q.size() < 1 || nack_q[0] !== 1'b0) begin fails++; $display("FAIL anack_next_nack got=%0d entries exp=one with nack 0", nack_q.size()); end
    tests++; if (byte_q.size() != int'(l) + 2) begin fails++; $display("FAIL anack_next_bytes got=%0d exp=%0d", byte_q.size(), int'(l) + 2); end
  endtask

  task automatic test_data_nack();
    logic [6:0]  a;
    logic [31:0] d;
    bit ok, ok2;
    a = 7'($urandom); d = $urandom;
    set_req(0, a, 2'd3, d);
    clear_logs(); auto_drop = 1'b1; eng_lat = $urandom_range(0, 3); nack_at = 2;
    expect_txn(a, 2'd3, d, 2);
    req_valid = 2'b01;
    wait_dones(1, 200, ok);
    wait_idle(GAP + 20, ok2);
    model_rr = 1;
    tests++; if (!(ok && ok2)) begin fails++; $display("FAIL dnack_timeout got=%b%b exp=11", ok, ok2); end
    tests++; if (byte_q.size() != exp_q.size()) begin fails++; $display("FAIL dnack_byte_count got=%0d exp=%0d", byte_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      tests++; if (byte_q[i] !== exp_q[i]) begin fails++; $display("FAIL dnack_byte%0d got=%h exp=%h", i, byte_q[i], exp_q[i]); end
    end
    if (done_q.size() > 0 && hrise_q.size() > 0 && rdy_cyc_q.size() > 0) begin
      tests++; if (nack_q[0] !== 1'b1) begin fails++; $display("FAIL dnack_nack got=%b exp=1", nack_q[0]); end
      tests++;
      if (done_cyc_q[0] != rdy_cyc_q[rdy_cyc_q.size()-1] || hrise_q[0] != done_cyc_q[0]) begin
        fails++; $display("FAIL dnack_timing got done=%0d halt=%0d exp=%0d", done_cyc_q[0], hrise_q[0], rdy_cyc_q[rdy_cyc_q.size()-1]);
      end
    end else begin
      tests++; fails++; $display("FAIL dnack_events got=%0d/%0d exp=1/1", done_q.size(), hrise_q.size());
    end
  endtask

  task automatic test_reset_mid();
    logic [6:0]  ra[NREQ];
    logic [1:0]  rl[NREQ];
    logic [31:0] rd[NREQ];
    bit ok;
    set_req(0, 7'($urandom), 2'd3, $urandom);
    clear_logs(); auto_drop = 1'b1; eng_lat = 3; nack_at = 99;
    req_valid = 2'b01;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (byte_q.size() >= 2) ok = 1'b1;
    end
    @(negedge clk);
    tests++; if (!ok) begin fails++; $display("FAIL rmid_reach_data got=%0d bytes exp=2", byte_q.size()); end
    for (int unsigned i = 0; i < NREQ; i++) begin
      ra[i] = 7'($urandom); rl[i] = 2'($urandom); rd[i] = $urandom;
      set_req(i, ra[i], rl[i], rd[i]);
    end
    reset_n = 1'b0; req_valid = 2'b11;
    clear_logs();
    @(negedge clk);
    tests++; if (eng_halt !== 1'b1) begin fails++; $display("FAIL rmid_halt got=%b exp=1", eng_halt); end
    tests++; if (eng_enable !== 1'b0) begin fails++; $display("FAIL rmid_enable got=%b exp=0", eng_enable); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    tests++; if (req_done !== '0 || done_q.size() != 0) begin fails++; $display("FAIL rmid_no_done got=%b/%0d exp=0/0", req_done, done_q.size()); end
    clear_logs();
    reset_n = 1'b1; model_rr = 0;
    wait_dones(2, 2 * (GAP + 60), ok);
    req_valid = '0;
    tests++; if (!ok) begin fails++; $display("FAIL rmid_timeout got=%0d dones exp=2", done_q.size()); end
    for (int t = 0; t < 2; t++) begin
      int unsigned g;
      g = rr_pick(2'b11);
      model_rr = (g + 1) % NREQ;
      expect_txn(ra[g], rl[g], rd[g], 99);
    end
    tests++; if (ack_q.size() < 1 || ack_q[0] !== 2'b01) begin fails++; $display("FAIL rmid_first_grant got=%0d acks exp=first 01", ack_q.size()); end
    tests++; if (byte_q.size() != exp_q.size()) begin fails++; $display("FAIL rmid_byte_count got=%0d exp=%0d", byte_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      tests++; if (byte_q[i] !== exp_q[i]) begin fails++; $display("FAIL rmid_byte%0d got=%h exp=%h", i, byte_q[i], exp_q[i]); end
    end
    wait_idle(GAP + 20, ok);
  endtask

  task automatic test_shadow();
    logic [6:0]  a;
    logic [31:0] d;
    bit ok, ok2;
    a = 7'($urandom); d = $urandom;
    set_req(0, a, 2'd3, d);
    clear_logs(); auto_drop = 1'b1; eng_lat = 1; nack_at = 99;
    expect_txn(a, 2'd3, d, 99);
    req_valid = 2'b01;
    wait_acks(1, 20, ok);
    set_req(0, ~a, 2'($urandom), ~d);
    wait_dones(1, 200, ok2);
    tests++; if (!(ok && ok2)) begin fails++; $display("FAIL shadow_timeout got=%b%b exp=11", ok, ok2); end
    wait_idle(GAP + 20, ok);
    repeat (3) @(negedge clk);
    model_rr = 1;
    tests++; if (ack_q.size() != 1) begin fails++; $display("FAIL shadow_ack_count got=%0d exp=1", ack_q.size()); end
    tests++; if (byte_q.size() != exp_q.size()) begin fails++; $display("FAIL shadow_byte_count got=%0d exp=%0d", byte_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
      tests++; if (byte_q[i] !== exp_q[i]) begin fails++; $display("FAIL shadow_byte%0d got=%h exp=%h", i, byte_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_random();
    logic [6:0]      ra[NREQ];
    logic [1:0]      rl[NREQ];
    logic [31:0]     rd[NREQ];
    logic [NREQ-1:0] mask;
    logic [NREQ-1:0] expg;
    int unsigned     g;
    int              na;
    bit ok, ok2;
    for (int it = 0; it < 10; it++) begin
      mask = NREQ'($urandom_range(1, 3));
      for (int unsigned i = 0; i < NREQ; i++) begin
        ra[i] = 7'($urandom); rl[i] = 2'($urandom); rd[i] = $urandom;
        set_req(i, ra[i], rl[i], rd[i]);
      end
      na = $urandom_range(0, 6);
      nack_at = na; eng_lat = $urandom_range(0, 3); auto_drop = 1'b1;
      clear_logs();
      g = rr_pick(mask);
      model_rr = (g + 1) % NREQ;
      expg = NREQ'(1 << g);
      expect_txn(ra[g], rl[g], rd[g], na);
      req_valid = mask;
      wait_dones(1, 300, ok);
      req_valid = '0;
      wait_idle(GAP + 20, ok2);
      tests++; if (!(ok && ok2)) begin fails++; $display("FAIL rand%0d_timeout got=%b%b exp=11", it, ok, ok2); end
      if (ack_q.size() > 0 && done_q.size() > 0) begin
        tests++; if (ack_q[0] !== expg) begin fails++; $display("FAIL rand%0d_ack got=%b exp=%b", it, ack_q[0], expg); end
        tests++; if (done_q[0] !== expg) begin fails++; $display("FAIL rand%0d_done got=%b exp=%b", it, done_q[0], expg); end
        tests++;
        if (nack_q[0] !== (na <= int'(rl[g]) + 1)) begin
          fails++; $display("FAIL rand%0d_nack got=%b exp=%b", it, nack_q[0], (na <= int'(rl[g]) + 1));
        end
      end
      tests++; if (byte_q.size() != exp_q.size()) begin fails++; $display("FAIL rand%0d_byte_count got=%0d exp=%0d", it, byte_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < byte_q.size(); i++) begin
        tests++; if (byte_q[i] !== exp_q[i]) begin fails++; $display("FAIL rand%0d_byte%0d got=%h exp=%h", it, i, byte_q[i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single();
    test_addr_nack();
    test_data_nack();
    test_reset_mid();
    test_shadow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
